// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants and helpers for the integer register file and its busy scoreboard.
//   RF_XLEN : data width
//   RF_NREG : number of architectural registers (x0 hardwired to zero)
//   RF_AW   : register address width
package reg_file_scoreboard_pkg;

  localparam int unsigned RF_XLEN = 32;
  localparam int unsigned RF_NREG = 32;
  localparam int unsigned RF_AW   = $clog2(RF_NREG);

  typedef logic [RF_AW-1:0]   rf_addr_t;
  typedef logic [RF_XLEN-1:0] rf_data_t;

  localparam rf_addr_t RF_X0 = '0;

  function automatic logic is_x0(input rf_addr_t a);
    return a == RF_X0;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard_sb.sv
// rf_scoreboard: per-register busy vector tracking pending writes, plus RAW/WAW hazard detection.
//   i_clk, i_rst            clock, async active-high reset
//   i_wb_en, i_wb_rd        write-back port (clears busy)
//   i_rs1_addr, i_rs2_addr  source operands checked for RAW
//   i_issue_en, i_issue_rd  destination claim (sets busy, checked for WAW)
//   o_stall                 hazard, issue not accepted
//   o_busy                  registered busy vector
module rf_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = RF_NREG,
  parameter int unsigned AW   = RF_AW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wb_en,
  input  logic [AW-1:0]   i_wb_rd,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  input  logic            i_issue_en,
  input  logic [AW-1:0]   i_issue_rd,
  output logic            o_stall,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic            w_pend_rs1;
  logic            w_pend_rs2;
  logic            w_pend_rd;
  logic            w_issue_ok;

  // A register is pending unless it is x0 or being retired this very cycle.
  function automatic logic pend(input logic [AW-1:0] r, input logic [NREG-1:0] busy,
                                input logic wb_en, input logic [AW-1:0] wb_rd);
    return (r != '0) && busy[r] && !(wb_en && (wb_rd == r));
  endfunction

  always_comb begin
    w_pend_rs1 = pend(i_rs1_addr, r_busy, i_wb_en, i_wb_rd);
    w_pend_rs2 = pend(i_rs2_addr, r_busy, i_wb_en, i_wb_rd);
    w_pend_rd  = pend(i_issue_rd, r_busy, i_wb_en, i_wb_rd);
    o_stall    = w_pend_rs1 | w_pend_rs2 | (i_issue_en & w_pend_rd);
    w_issue_ok = i_issue_en && !o_stall && (i_issue_rd != '0);
  end

  // Clear first, then set: a same-cycle claim on the retiring register keeps it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (i_wb_en && (i_wb_rd != '0)) w_busy_next[i_wb_rd] = 1'b0;
    if (w_issue_ok)                 w_busy_next[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: architectural integer register file with write-first bypass and a
// busy scoreboard that stalls decode on RAW/WAW hazards until write-back retires.
//   i_clk, i_rst                      clock, async active-high reset
//   i_wb_en, i_wb_rd, i_wb_data       write-back write port
//   i_rs1_addr/o_rs1_data             source 1 read (combinational, bypassed)
//   i_rs2_addr/o_rs2_data             source 2 read (combinational, bypassed)
//   i_issue_en, i_issue_rd            destination claim at issue
//   o_stall                           hazard, hold decode
//   o_busy                            registered scoreboard vector
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN,
  parameter int unsigned NREG = RF_NREG,
  parameter int unsigned AW   = RF_AW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wb_en,
  input  logic [AW-1:0]   i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_issue_en,
  input  logic [AW-1:0]   i_issue_rd,
  output logic            o_stall,
  output logic [NREG-1:0] o_busy
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr;
  logic            w_byp_en;

  assign w_wr = i_wb_en && (i_wb_rd != '0);
  // Reads must show zero while reset is held, so the bypass is masked too.
  assign w_byp_en = i_wb_en && !i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  always_comb begin
    o_rs1_data = '0;
    if (i_rs1_addr != '0) begin
      if (w_byp_en && (i_wb_rd == i_rs1_addr)) o_rs1_data = i_wb_data;
      else                                     o_rs1_data = r_regs[i_rs1_addr];
    end
  end

  always_comb begin
    o_rs2_data = '0;
    if (i_rs2_addr != '0) begin
      if (w_byp_en && (i_wb_rd == i_rs2_addr)) o_rs2_data = i_wb_data;
      else                                     o_rs2_data = r_regs[i_rs2_addr];
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wb_en    (i_wb_en),
    .i_wb_rd    (i_wb_rd),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .i_issue_en (i_issue_en),
    .i_issue_rd (i_issue_rd),
    .o_stall    (o_stall),
    .o_busy     (o_busy)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: a driver applies one input set per cycle and
// pushes the reference model's expected outputs; a monitor pops and compares mid-cycle.
module tb_reg_file_scoreboard;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wb_en = 1'b0;
  logic [4:0]  i_wb_rd = '0;
  logic [31:0] i_wb_data = '0;
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic        i_issue_en = 1'b0;
  logic [4:0]  i_issue_rd = '0;
  logic        o_stall;
  logic [31:0] o_busy;

  reg_file_scoreboard #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wb_en    (i_wb_en),
    .i_wb_rd    (i_wb_rd),
    .i_wb_data  (i_wb_data),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data),
    .i_issue_en (i_issue_en),
    .i_issue_rd (i_issue_rd),
    .o_stall    (o_stall),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: plain arrays of register contents and outstanding-write flags.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic bit m_pending(int r);
    if (r == 0) return 0;
    if (!m_busy[r]) return 0;
    if (i_wb_en && int'(i_wb_rd) == r) return 0;
    return 1;
  endfunction

  function automatic bit m_stall();
    if (i_rst) return 0;
    return m_pending(int'(i_rs1_addr)) || m_pending(int'(i_rs2_addr)) ||
           (i_issue_en && m_pending(int'(i_issue_rd)));
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (i_rst || a == 0) return 32'd0;
    if (i_wb_en && int'(i_wb_rd) == a) return i_wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int k = 0; k < 32; k++) v[k] = m_busy[k];
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 32; k++) begin
      m_regs[k] = 32'd0;
      m_busy[k] = 0;
    end
  endtask

  // Applies the rules for the edge that just happened, using the inputs held across it.
  task automatic m_clock();
    bit stall;
    if (i_rst) begin
      m_reset();
    end else begin
      stall = m_stall();
      if (i_wb_en && i_wb_rd != 0) begin
        m_regs[i_wb_rd] = i_wb_data;
        m_busy[i_wb_rd] = 0;
      end
      if (i_issue_en && !stall && i_issue_rd != 0) m_busy[i_issue_rd] = 1;
    end
  endtask

  task automatic step(input string tag, input bit rst, input bit wen, input int wrd,
                      input logic [31:0] wdata, input int a1, input int a2,
                      input bit ien, input int ird);
    exp_t e;
    @(posedge i_clk);
    m_clock();
    #1;
    i_rst = rst;
    if (rst) m_reset();
    i_wb_en = wen; i_wb_rd = 5'(wrd); i_wb_data = wdata;
    i_rs1_addr = 5'(a1); i_rs2_addr = 5'(a2);
    i_issue_en = ien; i_issue_rd = 5'(ird);
    e.tag   = tag;
    e.rs1   = m_read(a1);
    e.rs2   = m_read(a2);
    e.stall = m_stall();
    e.busy  = m_busy_vec();
    exp_q.push_back(e);
  endtask

  // Monitor: compares at the falling edge, away from the sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (o_rs1_data !== e.rs1) begin
          n_bad++; $display("FAIL %s rs1: got %h expected %h", e.tag, o_rs1_data, e.rs1);
        end
        n_cmp++;
        if (o_rs2_data !== e.rs2) begin
          n_bad++; $display("FAIL %s rs2: got %h expected %h", e.tag, o_rs2_data, e.rs2);
        end
        n_cmp++;
        if (o_stall !== e.stall) begin
          n_bad++; $display("FAIL %s stall: got %b expected %b", e.tag, o_stall, e.stall);
        end
        n_cmp++;
        if (o_busy !== e.busy) begin
          n_bad++; $display("FAIL %s busy: got %h expected %h", e.tag, o_busy, e.busy);
        end
      end
    end
  end

  initial begin
    int wrd, a1, a2, ird;
    bit wen, ien, rst;
    m_reset();
    // Reset release and initial state.
    step("rst_hold", 1, 0, 0, 0, 1, 2, 0, 0);
    step("rst_rel",  0, 0, 0, 0, 1, 2, 0, 0);

    // Write then read; write to x0 dropped.
    step("wr_x5",     0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step("rd_x5",     0, 0, 0, 0, 5, 0, 0, 0);
    step("wr_x0",     0, 1, 0, 32'h00001234, 0, 0, 0, 0);
    step("rd_x0",     0, 0, 0, 0, 5, 0, 0, 0);

    // Write-first bypass on both ports.
    step("byp_x7",    0, 1, 7, 32'hA5A5A5A5, 7, 7, 0, 0);
    step("rd_x7",     0, 0, 0, 0, 7, 7, 0, 0);

    // RAW on x3.
    step("iss_x3",    0, 0, 0, 0, 0, 0, 1, 3);
    step("raw_x3_a",  0, 0, 0, 0, 3, 0, 0, 0);
    step("raw_x3_b",  0, 0, 0, 0, 3, 0, 0, 0);
    step("wb_x3",     0, 1, 3, 32'h13579BDF, 3, 0, 0, 0);
    step("post_x3",   0, 0, 0, 0, 0, 3, 0, 0);

    // WAW and same-cycle set-wins on x9.
    step("iss_x9",    0, 0, 0, 0, 0, 0, 1, 9);
    step("waw_x9",    0, 0, 0, 0, 0, 0, 1, 9);
    step("setwin_x9", 0, 1, 9, 32'h99999999, 0, 0, 1, 9);
    step("busy_x9",   0, 0, 0, 0, 9, 0, 0, 0);
    step("wb_x9",     0, 1, 9, 32'h12121212, 0, 0, 0, 0);
    step("wb_nobusy", 0, 1, 11, 32'h0BADF00D, 11, 0, 0, 0);

    // x0 claims never set busy nor stall.
    for (int k = 0; k < 10; k++) step("iss_x0", 0, 0, 0, 0, 0, 0, 1, 0);

    // Mid-run reset after writes and outstanding claims.
    step("pre_rst_i", 0, 0, 0, 0, 0, 0, 1, 12);
    step("mid_rst",   1, 1, 5, 32'hFFFFFFFF, 5, 12, 1, 4);
    step("after_rst", 0, 0, 0, 0, 5, 7, 0, 0);

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      wen = ($urandom_range(0, 2) != 0);
      wrd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      a1  = int'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 7));
      ien = ($urandom_range(0, 1) == 0);
      ird = int'($urandom_range(0, 7));
      step("rand", rst, wen, wrd, $urandom, a1, a2, ien, ird);
    end

    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge i_clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
